seven_segment_capture: RTL and testbench

- Receive-side counterpart of the multiplexed seven-segment driver. Samples the time-multiplexed active-low anode/cathode lines and recovers, per digit, the hex nibble and decimal point being shown.
- Used as a loopback monitor in display-subsystem benches and on hardware as a readback/self-test path, e.g. to capture an external board's display.

---
 rtl/seven_segment_pkg.sv | 36 +++
 rtl/seven_segment_glyph_decode.sv | 18 +
 rtl/seven_segment_capture.sv | 193 +++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment capture path.
//   - Segment bit positions within an 8-bit cathode word.
//   - The 16-entry hex glyph table, active-high gfedcba.
//   - glyph_decode(): maps 7 active-high segments to {hit, nibble}.
//   - capture_state_e: capture FSM states, also exported for debug.
package seven_segment_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Index = nibble value. The decimal point is not part of any glyph.
    localparam logic [6:0] GLYPH_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } capture_state_e;

    // Returns {hit, nibble}. On a miss the result is all zero.
    function automatic logic [4:0] glyph_decode(input logic [6:0] segments);
        logic [4:0] result;
        result = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (segments == GLYPH_TABLE[i]) begin
                result = {1'b1, 4'(i)};
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/seven_segment_glyph_decode.sv
// Combinational glyph decoder.
// Ports:
//   segments : in  7  active-high segments, [0]=a .. [6]=g
//   hit      : out 1  segments form one of the 16 hex glyphs
//   nibble   : out 4  hex value of the glyph (0 on a miss)
module seven_segment_glyph_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] segments,
    output logic       hit,
    output logic [3:0] nibble
);

    always_comb begin
        {hit, nibble} = glyph_decode(segments);
    end

endmodule

// File: rtl/seven_segment_capture.sv
// Recovers per-digit hex values from time-multiplexed, active-low
// anode/cathode display lines.
// Ports:
//   clk, reset      : system clock, synchronous active-high reset
//   anode_in        : in  NUM_SEGMENTS active-low digit enables (async)
//   cathode_in      : in  8  active-low segments, [7]=dp (async)
//   encoded         : out NUM_SEGMENTS*4, digit i at [4*i +: 4]
//   digit_point     : out NUM_SEGMENTS, last captured dp per digit
//   digit_valid     : out NUM_SEGMENTS, digit holds a recognized, fresh value
//   capture_strobe  : out 1  one-cycle pulse per capture
//   capture_index   : out digit index of the last capture
//   pattern_error   : out 1  one-cycle pulse when a capture is not a glyph
//   fsm_state       : out capture FSM state, for debug/checkers
//
// Output timing: capture_strobe is a single-cycle qualifier with no
// back-pressure. In the cycle it is high, capture_index, pattern_error and
// the indexed encoded/digit_point/digit_valid entries already reflect that
// capture.
module seven_segment_capture
    import seven_segment_pkg::*;
#(
    parameter  int NUM_SEGMENTS   = 8,
    parameter  int SETTLE_CYCLES  = 16,
    parameter  int TIMEOUT_CYCLES = 262144,
    localparam int IDX_W          = (NUM_SEGMENTS > 1) ? $clog2(NUM_SEGMENTS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_SEGMENTS-1:0]   anode_in,
    input  logic [7:0]                cathode_in,
    output logic [NUM_SEGMENTS*4-1:0] encoded,
    output logic [NUM_SEGMENTS-1:0]   digit_point,
    output logic [NUM_SEGMENTS-1:0]   digit_valid,
    output logic                      capture_strobe,
    output logic [IDX_W-1:0]          capture_index,
    output logic                      pattern_error,
    output capture_state_e            fsm_state
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Two-flop synchronizers. They reset to all-ones (lines inactive) so the
    // FSM sees an illegal, idle sample right after reset.
    logic [NUM_SEGMENTS-1:0] anode_s1, anode_s2;
    logic [7:0]              cath_s1, cath_s2;

    always_ff @(posedge clk) begin
        if (reset) begin
            anode_s1 <= '1;
            anode_s2 <= '1;
            cath_s1  <= '1;
            cath_s2  <= '1;
        end else begin
            anode_s1 <= anode_in;
            anode_s2 <= anode_s1;
            cath_s1  <= cathode_in;
            cath_s2  <= cath_s1;
        end
    end

    // Capture FSM
    capture_state_e          state, state_n;
    logic [NUM_SEGMENTS-1:0] ref_anode, ref_anode_n;
    logic [7:0]              ref_cathode, ref_cathode_n;
    logic [CNT_W-1:0]        settle_cnt, settle_cnt_n;
    logic                    capture;
    logic                    sample_legal;
    logic                    sample_match;

    assign sample_legal = $onehot(~anode_s2);
    assign sample_match = (anode_s2 == ref_anode) && (cath_s2 == ref_cathode);
    assign fsm_state    = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            ref_anode   <= '0;
            ref_cathode <= '0;
            settle_cnt  <= '0;
        end else begin
            state       <= state_n;
            ref_anode   <= ref_anode_n;
            ref_cathode <= ref_cathode_n;
            settle_cnt  <= settle_cnt_n;
        end
    end

    always_comb begin
        state_n       = state;
        ref_anode_n   = ref_anode;
        ref_cathode_n = ref_cathode;
        settle_cnt_n  = settle_cnt;
        capture       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (sample_legal) begin
                    ref_anode_n   = anode_s2;
                    ref_cathode_n = cath_s2;
                    settle_cnt_n  = CNT_W'(1);
                    state_n       = ST_SETTLE;
                end
            end
            ST_SETTLE, ST_HOLD: begin
                if (sample_match) begin
                    // HOLD just sits on an unchanged pattern; only SETTLE counts.
                    if (state == ST_SETTLE) begin
                        if (settle_cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
                            capture      = 1'b1;
                            settle_cnt_n = CNT_W'(SETTLE_CYCLES);
                            state_n      = ST_HOLD;
                        end else begin
                            settle_cnt_n = settle_cnt + CNT_W'(1);
                        end
                    end
                end else if (sample_legal) begin
                    ref_anode_n   = anode_s2;
                    ref_cathode_n = cath_s2;
                    settle_cnt_n  = CNT_W'(1);
                    state_n       = ST_SETTLE;
                end else begin
                    settle_cnt_n  = '0;
                    state_n       = ST_IDLE;
                end
            end
            default: begin
                settle_cnt_n = '0;
                state_n      = ST_IDLE;
            end
        endcase
    end

    // The captured pattern equals the reference, so decode from the reference.
    logic [IDX_W-1:0] cap_idx;
    logic             glyph_hit;
    logic [3:0]       glyph_nibble;

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (!ref_anode[i]) begin
                cap_idx = IDX_W'(i);
            end
        end
    end

    seven_segment_glyph_decode u_decode (
        .segments (~ref_cathode[SEG_G:SEG_A]),
        .hit      (glyph_hit),
        .nibble   (glyph_nibble)
    );

    // Per-digit registers and staleness timers.
    logic [TO_W-1:0] timeout_cnt [NUM_SEGMENTS];

    always_ff @(posedge clk) begin
        if (reset) begin
            encoded        <= '0;
            digit_point    <= '0;
            digit_valid    <= '0;
            capture_strobe <= 1'b0;
            capture_index  <= '0;
            pattern_error  <= 1'b0;
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                timeout_cnt[i] <= '0;
            end
        end else begin
            capture_strobe <= capture;
            pattern_error  <= capture && !glyph_hit;
            if (capture) begin
                capture_index <= cap_idx;
            end
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                // A capture on the timeout edge takes priority and refreshes.
                if (capture && (cap_idx == IDX_W'(i))) begin
                    timeout_cnt[i] <= '0;
                    digit_point[i] <= ~ref_cathode[SEG_DP];
                    digit_valid[i] <= glyph_hit;
                    if (glyph_hit) begin
                        encoded[4*i +: 4] <= glyph_nibble;
                    end
                end else if (timeout_cnt[i] != TO_W'(TIMEOUT_CYCLES)) begin
                    timeout_cnt[i] <= timeout_cnt[i] + TO_W'(1);
                    if (timeout_cnt[i] == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        digit_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture. Expected captures are queued
// when a pattern is driven and popped when capture_strobe appears.
module tb_seven_segment_capture;
    import seven_segment_pkg::*;

    localparam int N  = 8;
    localparam int S  = 16;
    localparam int TO = 1000;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   anode_in;
    logic [7:0]     cathode_in;
    logic [N*4-1:0] encoded;
    logic [N-1:0]   digit_point;
    logic [N-1:0]   digit_valid;
    logic           capture_strobe;
    logic [2:0]     capture_index;
    logic           pattern_error;
    capture_state_e fsm_state;

    seven_segment_capture #(
        .NUM_SEGMENTS   (N),
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .anode_in       (anode_in),
        .cathode_in     (cathode_in),
        .encoded        (encoded),
        .digit_point    (digit_point),
        .digit_valid    (digit_valid),
        .capture_strobe (capture_strobe),
        .capture_index  (capture_index),
        .pattern_error  (pattern_error),
        .fsm_state      (fsm_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    // Scoreboard state
    // Entry: {2'b0, capture_cycle[19:0], index[2:0], nibble[3:0], dp, valid, perr}
    logic [31:0] exp_q[$];
    logic [3:0]  m_enc [N];
    logic [N-1:0] m_dp;
    logic [N-1:0] m_valid;
    logic [6:0]  seg_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next falling edge and sample outputs there.
    task automatic tick();
        @(negedge clk);
        #1;
        if (capture_strobe === 1'b1) strobe_cnt++;
    endtask

    // Drive one pattern and wait for the capture it should produce.
    task automatic drive_and_expect(input logic [7:0] an, input logic [7:0] ca,
                                    input int idx, input logic [3:0] nib,
                                    input logic hit, output int cap_cyc);
        int          t;
        int          base;
        bit          got;
        logic [3:0]  en;
        logic [31:0] e;
        logic [19:0] tc;
        anode_in   = an;
        cathode_in = ca;
        t  = cyc + 1 + S + 1;
        tc = t[19:0];
        en = hit ? nib : m_enc[idx];
        m_enc[idx]   = en;
        m_dp[idx]    = ~ca[7];
        m_valid[idx] = hit;
        exp_q.push_back({2'b00, tc, 3'(idx), en, ~ca[7], hit, ~hit});
        base = strobe_cnt;
        got  = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            tick();
            if (capture_strobe === 1'b1) got = 1'b1;
        end
        cap_cyc = cyc;
        check("strobe_seen", 64'(got), 64'd1);
        e = exp_q.pop_front();
        if (got) begin
            check("capture_cycle", 64'(cyc), 64'(e[29:10]));
            check("strobe_once", 64'(strobe_cnt - base), 64'd1);
            check("capture_index", 64'(capture_index), 64'(e[9:7]));
            check("encoded_digit", 64'(encoded[idx*4 +: 4]), 64'(e[6:3]));
            check("digit_point", 64'(digit_point[idx]), 64'(e[2]));
            check("digit_valid", 64'(digit_valid[idx]), 64'(e[1]));
            check("pattern_error", 64'(pattern_error), 64'(e[0]));
        end
    endtask

    function automatic logic [N*4-1:0] model_encoded();
        logic [N*4-1:0] v;
        for (int i = 0; i < N; i++) v[i*4 +: 4] = m_enc[i];
        return v;
    endfunction

    initial begin
        int base;
        int c;
        int c0;
        int c2;
        logic [31:0] val;
        logic [7:0]  dps;
        logic [3:0]  nb;

        for (int i = 0; i < N; i++) m_enc[i] = 4'h0;
        m_dp    = '0;
        m_valid = '0;

        // 1. Reset with random inputs
        reset      = 1'b1;
        anode_in   = 8'($urandom);
        cathode_in = 8'($urandom);
        repeat (3) begin
            tick();
            anode_in   = 8'($urandom_range(0, 255));
            cathode_in = 8'($urandom_range(0, 255));
        end
        anode_in   = 8'hFF;
        cathode_in = 8'hFF;
        tick();
        check("rst_encoded", 64'(encoded), 64'd0);
        check("rst_digit_point", 64'(digit_point), 64'd0);
        check("rst_digit_valid", 64'(digit_valid), 64'd0);
        check("rst_index", 64'(capture_index), 64'd0);
        check("rst_perr", 64'(pattern_error), 64'd0);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        check("rst_no_strobes", 64'(strobe_cnt), 64'd0);
        reset = 1'b0;
        repeat (3) tick();

        // 2. Digit 0 showing '1', latency and no repeat while held
        drive_and_expect(8'hFE, 8'hF9, 0, 4'h1, 1'b1, c);
        check("hold_state", 64'(fsm_state), 64'(ST_HOLD));
        base = strobe_cnt;
        repeat (30) tick();
        check("no_recapture_hold", 64'(strobe_cnt - base), 64'd0);

        // 3. Glitch on digit 3 interrupts settling
        base = strobe_cnt;
        anode_in   = 8'hF7;
        cathode_in = 8'h92;
        repeat (10) tick();
        anode_in   = 8'hFF;
        repeat (5) tick();
        check("no_capture_glitch", 64'(strobe_cnt - base), 64'd0);
        drive_and_expect(8'hF7, 8'h92, 3, 4'h5, 1'b1, c);
        repeat (5) tick();

        // 4. Illegal anode patterns, then a blank glyph on digit 6
        base = strobe_cnt;
        anode_in = 8'hFC;
        repeat (100) tick();
        anode_in = 8'hFF;
        repeat (100) tick();
        check("no_capture_illegal", 64'(strobe_cnt - base), 64'd0);
        check("illegal_state", 64'(fsm_state), 64'(ST_IDLE));
        check("illegal_encoded", 64'(encoded), 64'(model_encoded()));
        check("illegal_valid", 64'(digit_valid), 64'(m_valid));
        check("illegal_dp", 64'(digit_point), 64'(m_dp));
        drive_and_expect(8'hBF, 8'hFF, 6, 4'h0, 1'b0, c);
        tick();
        check("perr_one_cycle", 64'(pattern_error), 64'd0);
        check("blank_encoded", 64'(encoded), 64'(model_encoded()));

        // 5. Timeout of digit 2
        drive_and_expect(8'hFB, 8'h08, 2, 4'hA, 1'b1, c);
        drive_and_expect(8'hFE, 8'hF9, 0, 4'h1, 1'b1, c0);
        while (cyc < c + TO - 1) tick();
        check("valid2_before_timeout", 64'(digit_valid[2]), 64'd1);
        tick();
        check("valid2_at_timeout", 64'(digit_valid[2]), 64'd0);
        check("enc2_kept", 64'(encoded[11:8]), 64'hA);
        check("dp2_kept", 64'(digit_point[2]), 64'd1);
        m_valid[2] = 1'b0;

        // 5b. Recapture landing exactly on the timeout edge
        drive_and_expect(8'hFB, 8'h08, 2, 4'hA, 1'b1, c);
        drive_and_expect(8'hFE, 8'hF9, 0, 4'h1, 1'b1, c0);
        while (cyc < c + TO - S - 2) tick();
        drive_and_expect(8'hFB, 8'h08, 2, 4'hA, 1'b1, c2);
        tick();
        check("valid2_after_recapture", 64'(digit_valid[2]), 64'd1);
        repeat (3) tick();
        check("valid2_still_set", 64'(digit_valid[2]), 64'd1);

        // 6. Driver-style scan of all digits
        val = 32'h0123_ABCD;
        dps = 8'h81;
        for (int i = 0; i < N; i++) begin
            nb = val[i*4 +: 4];
            drive_and_expect(~(8'h01 << i), ~{dps[i], seg_tab[nb]}, i, nb, 1'b1, c);
            repeat (4) tick();
        end
        check("scan_encoded", 64'(encoded), 64'h0123_ABCD);
        check("scan_digit_point", 64'(digit_point), 64'h81);
        check("scan_digit_valid", 64'(digit_valid), 64'hFF);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        anode_in   = 8'hFF;
        cathode_in = 8'hFF;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
